decode_stage: RTL and testbench

- Instruction decode stage and ID/EX pipeline register. It produces the alu_op, operand-select and control fields consumed by the execute-stage ALU.
- Takes one 32-bit RV32I-style instruction per cycle from fetch and registers the decoded fields for EX with 1-cycle latency.
- Handles downstream stall, pipeline flush and load-use hazard bubbles.

---
 rtl/decode_stage.sv | 267 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I-style instruction decode plus the ID/EX pipeline register.
// Decoded fields reach EX one cycle after acceptance. Downstream stall, flush
// and single-cycle load-use bubbles are handled here.
// Optional feature: define DECODE_MUL_EN to decode R-type mul
// (funct7 0000001, funct3 000) as alu_op 1001. Without it every funct7 0000001
// R-type encoding is illegal.
module decode_stage #(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          if_instr,
    output logic                 id_ready,
    input  logic                 ex_stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [3:0]           ex_alu_op,
    output logic [31:0]          ex_imm,
    output logic                 ex_use_imm,
    output logic [4:0]           ex_rs1,
    output logic [4:0]           ex_rs2,
    output logic [4:0]           ex_rd,
    output logic                 ex_reg_we,
    output logic                 ex_mem_rd,
    output logic                 ex_mem_wr,
    output logic                 ex_is_branch,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;
`ifdef DECODE_MUL_EN
    localparam logic [3:0] ALU_MUL = 4'b1001;
`endif
    localparam logic [3:0] ALU_LUI = 4'b1010;
    localparam logic [3:0] ALU_BEQ = 4'b1100;
    localparam logic [3:0] ALU_BNE = 4'b1101;
    localparam logic [3:0] ALU_BGT = 4'b1110;
    localparam logic [3:0] ALU_BLT = 4'b1111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_sh;
    logic [31:0] imm_u;

    logic [3:0]  d_alu_op;
    logic [31:0] d_imm;
    logic        d_use_imm;
    logic        d_reg_we;
    logic        d_mem_rd;
    logic        d_mem_wr;
    logic        d_is_branch;
    logic        d_illegal;
    logic        uses_rs1;
    logic        uses_rs2;

    logic        hazard;
    logic        load_use;
    logic        accept;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];

    assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                     if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_sh = {27'b0, if_instr[24:20]};
    assign imm_u  = {12'b0, if_instr[31:12]};

    // Decode the incoming instruction into the fields EX consumes.
    always_comb begin
        d_alu_op    = ALU_ADD;
        d_imm       = '0;
        d_use_imm   = 1'b0;
        d_reg_we    = 1'b0;
        d_mem_rd    = 1'b0;
        d_mem_wr    = 1'b0;
        d_is_branch = 1'b0;
        d_illegal   = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;

        case (opcode)
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                d_reg_we = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     d_alu_op = ALU_ADD;
                        else if (funct7 == F7_ALT) d_alu_op = ALU_SUB;
`ifdef DECODE_MUL_EN
                        else if (funct7 == 7'b0000001) d_alu_op = ALU_MUL;
`endif
                        else                       d_illegal = 1'b1;
                    end
                    3'b100: if (funct7 == F7_BASE) d_alu_op = ALU_XOR; else d_illegal = 1'b1;
                    3'b110: if (funct7 == F7_BASE) d_alu_op = ALU_OR;  else d_illegal = 1'b1;
                    3'b111: if (funct7 == F7_BASE) d_alu_op = ALU_AND; else d_illegal = 1'b1;
                    3'b001: if (funct7 == F7_BASE) d_alu_op = ALU_SLL; else d_illegal = 1'b1;
                    3'b010: if (funct7 == F7_BASE) d_alu_op = ALU_SLT; else d_illegal = 1'b1;
                    3'b101: begin
                        if (funct7 == F7_BASE)     d_alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) d_alu_op = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                uses_rs1  = 1'b1;
                d_use_imm = 1'b1;
                d_reg_we  = 1'b1;
                d_imm     = imm_i;
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b001: begin
                        d_imm = imm_sh;
                        if (funct7 == F7_BASE) d_alu_op = ALU_SLL; else d_illegal = 1'b1;
                    end
                    3'b101: begin
                        d_imm = imm_sh;
                        if (funct7 == F7_BASE)     d_alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) d_alu_op = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                d_imm     = imm_i;
                d_use_imm = 1'b1;
                d_reg_we  = 1'b1;
                d_mem_rd  = 1'b1;
                if (funct3 != 3'b010) d_illegal = 1'b1;
            end
            OP_STORE: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                d_imm     = imm_s;
                d_use_imm = 1'b1;
                d_mem_wr  = 1'b1;
                if (funct3 != 3'b010) d_illegal = 1'b1;
            end
            OP_LUI: begin
                d_alu_op  = ALU_LUI;
                d_imm     = imm_u;
                d_use_imm = 1'b1;
                d_reg_we  = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                d_is_branch = 1'b1;
                d_imm       = imm_b;
                case (funct3)
                    3'b000:  d_alu_op = ALU_BEQ;
                    3'b001:  d_alu_op = ALU_BNE;
                    3'b101:  d_alu_op = ALU_BGT;
                    3'b100:  d_alu_op = ALU_BLT;
                    default: d_illegal = 1'b1;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase

        // Illegal encodings reach EX as inert instructions with only the flag set.
        if (d_illegal) begin
            d_alu_op    = ALU_ADD;
            d_imm       = '0;
            d_use_imm   = 1'b0;
            d_reg_we    = 1'b0;
            d_mem_rd    = 1'b0;
            d_mem_wr    = 1'b0;
            d_is_branch = 1'b0;
        end

        if (rd == 5'd0) d_reg_we = 1'b0;
    end

    // Load-use detection against the load currently held in ID/EX.
    always_comb begin
        hazard   = ex_valid && ex_mem_rd && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
        load_use = if_valid && !flush && !ex_stall && hazard;
        accept   = if_valid && !flush && !ex_stall && !hazard;
        id_ready = flush || (!ex_stall && !load_use);
    end

    // ID/EX register update: rst > flush > stall > bubble > normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_reg_we    <= 1'b0;
            ex_mem_rd    <= 1'b0;
            ex_mem_wr    <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_illegal   <= 1'b0;
            ill_count    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (load_use) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_alu_op    <= d_alu_op;
            ex_imm       <= d_imm;
            ex_use_imm   <= d_use_imm;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_reg_we    <= d_reg_we;
            ex_mem_rd    <= d_mem_rd;
            ex_mem_wr    <= d_mem_wr;
            ex_is_branch <= d_is_branch;
            ex_illegal   <= d_illegal;
            if (d_illegal && !(&ill_count)) ill_count <= ill_count + 1'b1;
        end else begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table, hand-written hazard/stall/flush/reset
// sequences, and a randomized phase checked against a behavioural model.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_imm;
    logic        ex_use_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_is_branch;
    logic        ex_illegal;
    logic [7:0]  ill_count;

    int checks;
    int errors;

    decode_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm),
        .ex_use_imm(ex_use_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal), .ill_count(ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        chk_imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        br;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        chk_imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        br;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_rs1;
        logic        rd_rs2;
    } exp_t;

    exp_t m;
    int   m_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode built from the instruction-set tables.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] i12;
        logic [11:0] s12;
        logic [12:0] b13;
        int          v;
        e = '{default: '0};
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        case (op)
            7'h33: begin
                e.rd_rs1 = 1; e.rd_rs2 = 1; e.reg_we = 1;
                case ({f7, f3})
                    10'b0000000_000: e.alu = 4'd0;
                    10'b0100000_000: e.alu = 4'd1;
                    10'b0000000_100: e.alu = 4'd2;
                    10'b0000000_110: e.alu = 4'd3;
                    10'b0000000_111: e.alu = 4'd4;
                    10'b0000000_001: e.alu = 4'd5;
                    10'b0000000_101: e.alu = 4'd6;
                    10'b0100000_101: e.alu = 4'd7;
                    10'b0000000_010: e.alu = 4'd8;
`ifdef DECODE_MUL_EN
                    10'b0000001_000: e.alu = 4'd9;
`endif
                    default: e.ill = 1;
                endcase
            end
            7'h13: begin
                e.rd_rs1 = 1; e.use_imm = 1; e.reg_we = 1; e.chk_imm = 1;
                v = $signed(i12);
                e.imm = v;
                case (f3)
                    3'b000: e.alu = 4'd0;
                    3'b100: e.alu = 4'd2;
                    3'b110: e.alu = 4'd3;
                    3'b111: e.alu = 4'd4;
                    3'b010: e.alu = 4'd8;
                    3'b001: begin
                        e.imm = 32'(ins[24:20]);
                        if (f7 == 7'h00) e.alu = 4'd5; else e.ill = 1;
                    end
                    3'b101: begin
                        e.imm = 32'(ins[24:20]);
                        if (f7 == 7'h00) e.alu = 4'd6;
                        else if (f7 == 7'h20) e.alu = 4'd7;
                        else e.ill = 1;
                    end
                    default: e.ill = 1;
                endcase
            end
            7'h03: begin
                e.rd_rs1 = 1; e.use_imm = 1; e.reg_we = 1; e.mem_rd = 1; e.chk_imm = 1;
                v = $signed(i12);
                e.imm = v;
                e.ill = (f3 != 3'b010);
            end
            7'h23: begin
                e.rd_rs1 = 1; e.rd_rs2 = 1; e.use_imm = 1; e.mem_wr = 1; e.chk_imm = 1;
                v = $signed(s12);
                e.imm = v;
                e.ill = (f3 != 3'b010);
            end
            7'h37: begin
                e.alu = 4'd10; e.use_imm = 1; e.reg_we = 1; e.chk_imm = 1;
                e.imm = ins >> 12;
            end
            7'h63: begin
                e.rd_rs1 = 1; e.rd_rs2 = 1; e.br = 1; e.chk_imm = 1;
                v = $signed(b13);
                e.imm = v;
                if (f3 == 3'b000) e.alu = 4'd12;
                else if (f3 == 3'b001) e.alu = 4'd13;
                else if (f3 == 3'b101) e.alu = 4'd14;
                else if (f3 == 3'b100) e.alu = 4'd15;
                else e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.alu = 0; e.reg_we = 0; e.mem_rd = 0; e.mem_wr = 0; e.br = 0; e.chk_imm = 0;
        end
        if (e.rd == 0) e.reg_we = 0;
        return e;
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0: return 7'h00;
            1: return 7'h20;
            2: return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  a, b, d;
        logic [2:0]  f3;
        r  = $urandom;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        case ($urandom_range(0, 9))
            0, 1: return {pick_f7(), b, a, f3, d, 7'h33};
            2, 3: return {pick_f7(), r[24:20], a, f3, d, 7'h13};
            4:    return {r[31:20], a, ($urandom_range(0, 2) != 0) ? 3'b010 : f3, d, 7'h03};
            5:    return {r[31:25], b, a, ($urandom_range(0, 2) != 0) ? 3'b010 : f3, r[11:7], 7'h23};
            6:    return {r[31:25], b, a, f3, r[11:7], 7'h63};
            7:    return {r[31:12], d, 7'h37};
            8:    return r;
            default: return {r[31:20], a, 3'b010, d, 7'h03};
        endcase
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".ex_valid"}, ex_valid, m.valid);
        check({tag, ".ill_count"}, ill_count, m_ill);
        if (m.valid) begin
            check({tag, ".alu_op"}, ex_alu_op, m.alu);
            check({tag, ".reg_we"}, ex_reg_we, m.reg_we);
            check({tag, ".mem_rd"}, ex_mem_rd, m.mem_rd);
            check({tag, ".mem_wr"}, ex_mem_wr, m.mem_wr);
            check({tag, ".is_branch"}, ex_is_branch, m.br);
            check({tag, ".illegal"}, ex_illegal, m.ill);
            if (!m.ill) begin
                check({tag, ".use_imm"}, ex_use_imm, m.use_imm);
                check({tag, ".rs1"}, ex_rs1, m.rs1);
                check({tag, ".rs2"}, ex_rs2, m.rs2);
                check({tag, ".rd"}, ex_rd, m.rd);
            end
            if (m.chk_imm) check({tag, ".imm"}, ex_imm, m.imm);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"}, ex_valid, 0);
        check({tag, ".alu_op"}, ex_alu_op, 0);
        check({tag, ".imm"}, ex_imm, 0);
        check({tag, ".use_imm"}, ex_use_imm, 0);
        check({tag, ".rs1"}, ex_rs1, 0);
        check({tag, ".rs2"}, ex_rs2, 0);
        check({tag, ".rd"}, ex_rd, 0);
        check({tag, ".reg_we"}, ex_reg_we, 0);
        check({tag, ".mem_rd"}, ex_mem_rd, 0);
        check({tag, ".mem_wr"}, ex_mem_wr, 0);
        check({tag, ".is_branch"}, ex_is_branch, 0);
        check({tag, ".illegal"}, ex_illegal, 0);
        check({tag, ".ill_count"}, ill_count, 0);
    endtask

    vec_t vecs[$];
    int   exp_ill;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; ex_stall = 1'b0; flush = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("post_reset.ex_valid", ex_valid, 0);

        // ---------------- directed vector table ----------------
        //          instr         alu   imm           chk use we  mrd mwr br  ill
        vecs.push_back('{32'h002081B3, 4'h0, 32'h0,        0, 0, 1, 0, 0, 0, 0}); // add x3,x1,x2
        vecs.push_back('{32'h402081B3, 4'h1, 32'h0,        0, 0, 1, 0, 0, 0, 0}); // sub
`ifdef DECODE_MUL_EN
        vecs.push_back('{32'h022081B3, 4'h9, 32'h0,        0, 0, 1, 0, 0, 0, 0}); // mul
`else
        vecs.push_back('{32'h022081B3, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 1}); // mul -> illegal
`endif
        vecs.push_back('{32'h0040A283, 4'h0, 32'h4,        1, 1, 1, 1, 0, 0, 0}); // lw x5,4(x1)
        vecs.push_back('{32'h00208463, 4'hC, 32'h8,        1, 0, 0, 0, 0, 1, 0}); // beq +8
        vecs.push_back('{32'hFFF00093, 4'h0, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 0, 0}); // addi x1,x0,-1
        vecs.push_back('{32'h4030D113, 4'h7, 32'h3,        1, 1, 1, 0, 0, 0, 0}); // srai x2,x1,3
        vecs.push_back('{32'h0020A423, 4'h0, 32'h8,        1, 1, 0, 0, 1, 0, 0}); // sw x2,8(x1)
        vecs.push_back('{32'hFE20AE23, 4'h0, 32'hFFFFFFFC, 1, 1, 0, 0, 1, 0, 0}); // sw x2,-4(x1)
        vecs.push_back('{32'h123452B7, 4'hA, 32'h00012345, 1, 1, 1, 0, 0, 0, 0}); // lui x5
        vecs.push_back('{32'h00000013, 4'h0, 32'h0,        1, 1, 0, 0, 0, 0, 0}); // nop: rd=0
        vecs.push_back('{32'hFE20CCE3, 4'hF, 32'hFFFFFFF8, 1, 0, 0, 0, 0, 1, 0}); // blt -8
        vecs.push_back('{32'h0020D463, 4'hE, 32'h8,        1, 0, 0, 0, 0, 1, 0}); // bgt +8
        vecs.push_back('{32'h0020A1B3, 4'h8, 32'h0,        0, 0, 1, 0, 0, 0, 0}); // slt
        vecs.push_back('{32'h0020A463, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 1}); // branch f3=010
        vecs.push_back('{32'h0000007F, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 1}); // bad opcode
        vecs.push_back('{32'h00408283, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 1}); // lb
        vecs.push_back('{32'h0420C1B3, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 1}); // xor bad funct7

        exp_ill = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if_instr = vecs[i].instr;
            if_valid = 1'b1;
            #1;
            check($sformatf("vec%0d.id_ready", i), id_ready, 1);
            tick();
            if (vecs[i].ill) exp_ill++;
            check($sformatf("vec%0d.ex_valid", i), ex_valid, 1);
            check($sformatf("vec%0d.alu_op", i), ex_alu_op, vecs[i].alu);
            check($sformatf("vec%0d.reg_we", i), ex_reg_we, vecs[i].reg_we);
            check($sformatf("vec%0d.mem_rd", i), ex_mem_rd, vecs[i].mem_rd);
            check($sformatf("vec%0d.mem_wr", i), ex_mem_wr, vecs[i].mem_wr);
            check($sformatf("vec%0d.is_branch", i), ex_is_branch, vecs[i].br);
            check($sformatf("vec%0d.illegal", i), ex_illegal, vecs[i].ill);
            check($sformatf("vec%0d.ill_count", i), ill_count, exp_ill);
            if (!vecs[i].ill) check($sformatf("vec%0d.use_imm", i), ex_use_imm, vecs[i].use_imm);
            if (vecs[i].chk_imm) check($sformatf("vec%0d.imm", i), ex_imm, vecs[i].imm);
            if (i == 0) begin
                check("add.rs1", ex_rs1, 1);
                check("add.rs2", ex_rs2, 2);
                check("add.rd", ex_rd, 3);
            end
            if_valid = 1'b0;
            tick();
        end

        // ---------------- load-use bubble ----------------
        if_instr = 32'h0040A283; if_valid = 1'b1;
        tick();
        check("lu.lw.mem_rd", ex_mem_rd, 1);
        check("lu.lw.imm", ex_imm, 4);
        check("lu.lw.rd", ex_rd, 5);
        if_instr = 32'h00228333;
        #1;
        check("lu.id_ready_hazard", id_ready, 0);
        tick();
        check("lu.bubble.ex_valid", ex_valid, 0);
        #1;
        check("lu.id_ready_after", id_ready, 1);
        tick();
        check("lu.add.ex_valid", ex_valid, 1);
        check("lu.add.rs1", ex_rs1, 5);
        check("lu.add.rd", ex_rd, 6);
        check("lu.add.mem_rd", ex_mem_rd, 0);

        // ---------------- stall then flush ----------------
        if_instr = 32'h402081B3; if_valid = 1'b1; ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall.id_ready", id_ready, 0);
            tick();
            check("stall.ex_valid", ex_valid, 1);
            check("stall.alu_op", ex_alu_op, 0);
            check("stall.rd", ex_rd, 6);
        end
        ex_stall = 1'b0; flush = 1'b1;
        #1;
        check("flush.id_ready", id_ready, 1);
        tick();
        check("flush.ex_valid", ex_valid, 0);
        flush = 1'b0; if_valid = 1'b0;
        tick();
        check("flush.dropped", ex_valid, 0);

        // ---------------- randomized vs model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = '{default: '0};
        m_ill = 0;
        for (int i = 0; i < 3000; i++) begin
            exp_t d;
            logic hz, exp_ready;
            if (i == 1500) begin
                // async reset in the middle of traffic, away from any edge
                if_valid = 1'b1; if_instr = 32'h123452B7; ex_stall = 1'b0; flush = 1'b0;
                tick();
                check("areset.pre_valid", ex_valid, 1);
                #2;
                rst = 1'b1;
                #1;
                check_all_zero("areset");
                tick();
                rst = 1'b0;
                m = '{default: '0};
                m_ill = 0;
                continue;
            end
            if_valid = ($urandom_range(0, 9) < 8);
            ex_stall = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 8);
            if_instr = rand_instr();
            d  = model_decode(if_instr);
            hz = m.valid && m.mem_rd && (m.rd != 0) &&
                 ((d.rd_rs1 && d.rs1 == m.rd) || (d.rd_rs2 && d.rs2 == m.rd));
            exp_ready = flush || (!ex_stall && !(if_valid && hz));
            #1;
            check("rnd.id_ready", id_ready, exp_ready);
            if (flush) m.valid = 0;
            else if (ex_stall) m.valid = m.valid;
            else if (if_valid && hz) m.valid = 0;
            else if (if_valid) begin
                m = d;
                m.valid = 1;
                if (d.ill && m_ill < 255) m_ill++;
            end else m.valid = 0;
            tick();
            compare_model("rnd");
        end

        // ---------------- ill_count saturation ----------------
        if_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_instr = 32'h0000007F; if_valid = 1'b1;
        for (int c = 0; c < 254; c++) tick();
        check("sat.254", ill_count, 254);
        tick();
        check("sat.255", ill_count, 255);
        for (int c = 0; c < 5; c++) tick();
        check("sat.hold", ill_count, 255);
        check("sat.ex_illegal", ex_illegal, 1);
        if_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
